// File: rtl/stbuf_ring.sv
// Circular store buffer with youngest-match load forwarding and a dcache drain port.
// Define STBUF_COALESCE_EN to merge a store into the youngest entry when address and type match.
module stbuf_ring #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [AW-1:0]                st_addr,
  input  logic [DW-1:0]                st_data,
  input  logic                         st_byte,
  input  logic                         ld_valid,
  input  logic [AW-1:0]                ld_addr,
  input  logic                         ld_byte,
  output logic                         ld_hit,
  output logic [DW-1:0]                ld_data,
  output logic                         ld_stall,
  output logic                         dc_valid,
  input  logic                         dc_ready,
  output logic [AW-1:0]                dc_addr,
  output logic [DW-1:0]                dc_data,
  output logic                         dc_byte,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic             r_byte [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_cnt;

  logic          w_empty, w_full, w_pop, w_push, w_coal, w_alloc;
  logic [PW-1:0] w_ytail;
  logic          w_fnd, w_fbyte;
  logic [DW-1:0] w_fdata;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_ytail = r_tail - PW'(1);
  assign w_pop   = !w_empty && dc_ready;

`ifdef STBUF_COALESCE_EN
  // The youngest entry cannot absorb a store if it is leaving this cycle.
  assign w_coal = !w_empty && (r_addr[w_ytail] == st_addr) &&
                  (r_byte[w_ytail] == st_byte) && !(w_pop && (w_ytail == r_head));
`else
  assign w_coal = 1'b0;
`endif

  assign st_ready = !w_full || w_pop || w_coal;
  assign w_push   = st_valid && st_ready;
  assign w_alloc  = w_push && !w_coal;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      // Full push+pop hits the same slot; the set below must win over the clear.
      if (w_alloc) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end
      case ({w_alloc, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_alloc) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
      r_byte[r_tail] <= st_byte;
    end else if (reset && w_push && w_coal) begin
      r_data[w_ytail] <= st_data;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = r_head;
    w_fnd   = 1'b0;
    w_fbyte = 1'b0;
    w_fdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + PW'(i);
      if (r_vld[idx] && (r_addr[idx] == ld_addr)) begin
        w_fnd   = 1'b1;
        w_fbyte = r_byte[idx];
        w_fdata = r_data[idx];
      end
    end
  end

  assign ld_hit   = ld_valid && w_fnd && (w_fbyte == ld_byte);
  assign ld_stall = ld_valid && w_fnd && (w_fbyte != ld_byte);
  assign ld_data  = ld_hit ? w_fdata : '0;

  assign dc_valid = !w_empty;
  assign dc_addr  = dc_valid ? r_addr[r_head] : '0;
  assign dc_data  = dc_valid ? r_data[r_head] : '0;
  assign dc_byte  = dc_valid ? r_byte[r_head] : 1'b0;

  assign count = r_cnt;
  assign empty = w_empty;
  assign full  = w_full;
endmodule

// File: tb/tb_stbuf_ring.sv
// Scoreboard bench for stbuf_ring: a queue-based model predicts status and load results per cycle.
module tb_stbuf_ring;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int SW    = CW + AW + DW + 5;

  logic clk, reset;
  logic st_valid, st_ready, st_byte;
  logic [AW-1:0] st_addr, ld_addr, dc_addr;
  logic [DW-1:0] st_data, ld_data, dc_data;
  logic ld_valid, ld_byte, ld_hit, ld_stall;
  logic dc_valid, dc_ready, dc_byte;
  logic [CW-1:0] count;
  logic empty, full;

  stbuf_ring #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_addr(dc_addr), .dc_data(dc_data), .dc_byte(dc_byte),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic b; } ent_t;
  ent_t            mq[$];
  logic [SW-1:0]   sq[$];
  logic [DW+1:0]   lq[$];
  int n_chk, n_pass;
  bit armed;

  task automatic cycle(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic sb, input logic lv, input logic [AW-1:0] la, input logic lb,
                       input logic dr, input logic rs);
    ent_t e;
    bit pop, coal, rdy, found, hit;
    logic fb, hb;
    logic [DW-1:0] fd, hd;
    logic [AW-1:0] ha;
    int n;
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_data = sd; st_byte = sb;
    ld_valid = lv; ld_addr = la; ld_byte = lb;
    dc_ready = dr; reset = rs;
    #1;
    n    = mq.size();
    pop  = (n > 0) && dr;
    coal = 1'b0;
`ifdef STBUF_COALESCE_EN
    if (n > 0) coal = (mq[n-1].a == sa) && (mq[n-1].b == sb) && !(pop && n == 1);
`endif
    rdy = (n < DEPTH) || pop || coal;
    if (armed) begin
      ha = '0; hd = '0; hb = 1'b0;
      if (n > 0) begin ha = mq[0].a; hd = mq[0].d; hb = mq[0].b; end
      sq.push_back({CW'(n), n == 0, n == DEPTH, rdy, n > 0, ha, hd, hb});
      if (lv) begin
        found = 1'b0; fd = '0; fb = 1'b0;
        for (int i = n - 1; i >= 0; i--)
          if (!found && mq[i].a == la) begin found = 1'b1; fb = mq[i].b; fd = mq[i].d; end
        hit = found && (fb == lb);
        lq.push_back({hit, found && (fb != lb), hit ? fd : {DW{1'b0}}});
      end
    end
    if (!rs) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (sv && rdy) begin
        if (coal) mq[mq.size()-1].d = sd;
        else begin e.a = sa; e.d = sd; e.b = sb; mq.push_back(e); end
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic st(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic b);
    cycle(1'b1, a, d, b, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic ld(input logic [AW-1:0] a, input logic b);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, a, b, 1'b0, 1'b1);
  endtask

  // Monitor: compares whatever the DUT presents against the queued predictions.
  always @(negedge clk) begin
    logic [SW-1:0] se;
    logic [DW+1:0] le;
    #2;
    if (sq.size() > 0) begin
      se = sq.pop_front();
      n_chk++;
      if ({count, empty, full, st_ready, dc_valid, dc_addr, dc_data, dc_byte} === se) n_pass++;
      else $display("FAIL status t=%0t act=%h exp=%h", $time,
                    {count, empty, full, st_ready, dc_valid, dc_addr, dc_data, dc_byte}, se);
    end
    if (armed && ld_valid) begin
      n_chk++;
      if (lq.size() == 0) $display("FAIL load t=%0t no prediction queued", $time);
      else begin
        le = lq.pop_front();
        if ({ld_hit, ld_stall, ld_data} === le) n_pass++;
        else $display("FAIL load t=%0t act(hit,stall,data)=%h exp=%h", $time,
                      {ld_hit, ld_stall, ld_data}, le);
      end
    end
  end

  localparam logic [AW-1:0] ATAB [4] = '{32'h100, 32'h104, 32'h200, 32'h300};

  initial begin
    logic [31:0] r;
    n_chk = 0; n_pass = 0; armed = 1'b0;
    st_valid = 0; st_addr = '0; st_data = '0; st_byte = 0;
    ld_valid = 0; ld_addr = '0; ld_byte = 0; dc_ready = 0; reset = 0;
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    armed = 1'b1;
    // Reset state, including a load against the empty buffer.
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    // Fill, blocked push, then push-with-pop while full.
    for (int i = 0; i < DEPTH; i++) st(32'h1000 + 32'(4*i), 32'hA0 + 32'(i), 1'b0);
    cycle(1'b1, 32'h2000, 32'h55, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h2000, 32'h55, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle();
    // Drain everything through the wrapped head.
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b1);
    // Zero-data forwarding, type-mismatch stall, miss.
    st(32'h100, 32'hAAAA, 1'b0);
    st(32'h100, 32'h0000, 1'b0);
    ld(32'h100, 1'b0);
    st(32'h104, 32'h77, 1'b1);
    ld(32'h104, 1'b0);
    ld(32'h200, 1'b0);
    // Store and load to the same address in one cycle: not yet visible.
    cycle(1'b1, 32'h500, 32'h9, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
    ld(32'h500, 1'b0);
    // Reset overriding push and pop.
    for (int i = 0; i < 3; i++) st(32'h600 + 32'(i), 32'(i), 1'b0);
    cycle(1'b1, 32'h700, 32'h1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle();
    // Back-to-back word stores to one address.
    st(32'h300, 32'h1, 1'b0);
    st(32'h300, 32'h2, 1'b0);
    idle();
    // Randomized traffic over a small address set to force matches.
    for (int k = 0; k < 3000; k++) begin
      r = $urandom;
      cycle(r[0], ATAB[r[2:1]], $urandom, r[3], r[4], ATAB[r[6:5]], r[7],
            (r[10:8] < 3'd3), ($urandom_range(0, 149) != 0));
    end
    idle();
    @(negedge clk);
    #5;
    n_chk++;
    if (sq.size() == 0 && lq.size() == 0) n_pass++;
    else $display("FAIL drain sq=%0d lq=%0d left unconsumed", sq.size(), lq.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
